// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers packed {A, B} operand words and runs one
// MAC operation per word (present operands, multiplier reset, start,
// wait for done), then returns the captured sum on a valid/ready port.
// Optional watchdog on the WAIT state: define MAC_FEEDER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a queued word; pops the head when one is present
// LOAD  | operands presented, mul_rst pulsed
// START | start pulsed to the MAC controller
// WAIT  | waiting for mac_done (or watchdog expiry)
// EMIT  | result held on res_valid until res_ready
module mac_operand_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_data,
  output logic [7:0]                 data_a,
  output logic [7:0]                 data_b,
  output logic                       mul_rst,
  output logic                       start,
  input  logic                       mac_done,
  input  logic [7:0]                 mac_sum,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [7:0]                 res_data,
  output logic                       res_err,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push, pop;

  logic [2:0]    state_q, state_d;
  logic [7:0]    data_a_q, data_a_d;
  logic [7:0]    data_b_q, data_b_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [15:0]   head;

`ifdef MAC_FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic          res_err_q, res_err_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
`endif

  assign in_ready = (level_q != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sequencer next state: operand latch on pop, result capture in WAIT
  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    res_data_d = res_data_q;
    pop        = 1'b0;
`ifdef MAC_FEEDER_TIMEOUT_EN
    res_err_d  = res_err_q;
    wd_cnt_d   = wd_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop      = 1'b1;
          data_a_d = head[15:8];
          data_b_d = head[7:0];
          state_d  = LOAD;
        end
      end
      LOAD:  state_d = START;
      START: begin
        state_d = WAIT;
`ifdef MAC_FEEDER_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      WAIT: begin
        // a done coinciding with expiry takes priority: clean result
        if (mac_done) begin
          res_data_d = mac_sum;
          state_d    = EMIT;
`ifdef MAC_FEEDER_TIMEOUT_EN
          res_err_d  = 1'b0;
        end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
          res_data_d = mac_sum;
          res_err_d  = 1'b1;
          state_d    = EMIT;
        end else begin
          wd_cnt_d   = wd_cnt_q + CW'(1);
`endif
        end
      end
      EMIT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_a_q   <= '0;
      data_b_q   <= '0;
      res_data_q <= '0;
`ifdef MAC_FEEDER_TIMEOUT_EN
      res_err_q  <= 1'b0;
      wd_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      res_data_q <= res_data_d;
`ifdef MAC_FEEDER_TIMEOUT_EN
      res_err_q  <= res_err_d;
      wd_cnt_q   <= wd_cnt_d;
`endif
    end
  end

`ifdef MAC_FEEDER_TIMEOUT_EN
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign mul_rst   = (state_q == LOAD);
  assign start     = (state_q == START);
  assign res_valid = (state_q == EMIT);
  assign res_data  = res_data_q;
  assign busy      = (state_q != IDLE);
  assign level     = level_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder (DEPTH=4, TIMEOUT=8).
module tb_mac_operand_feeder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  data_a;
  logic [7:0]  data_b;
  logic        mul_rst;
  logic        start;
  logic        mac_done;
  logic [7:0]  mac_sum;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        res_err;
  logic        busy;
  logic [$clog2(DEPTH):0] level;

  int n_checks = 0;
  int n_fails  = 0;

  mac_operand_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .data_a(data_a), .data_b(data_b),
    .mul_rst(mul_rst), .start(start),
    .mac_done(mac_done), .mac_sum(mac_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .busy(busy), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  // complete the op currently in WAIT and accept its result
  task automatic finish_op(input string tag, input logic [7:0] s);
    mac_done = 1'b1;
    mac_sum  = s;
    tick();
    mac_done = 1'b0;
    check({tag, "_res_valid"}, res_valid, 1);
    check({tag, "_res_data"}, res_data, s);
    check({tag, "_res_err"}, res_err, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_res_valid_clr"}, res_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_data_a"}, data_a, 0);
    check({tag, "_data_b"}, data_b, 0);
    check({tag, "_mul_rst"}, mul_rst, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_level"}, level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] words [6];
    logic [15:0] w;
    logic [7:0]  s;
    int          hi;

    words[0] = 16'h1020; words[1] = 16'h3041; words[2] = 16'h5062;
    words[3] = 16'h7083; words[4] = 16'h90A4; words[5] = 16'hB0C5;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    mac_done = 1'b0; mac_sum = '0; res_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    tick();
    check("por_release_busy", busy, 0);

    // single op
    push_word(16'h0305);
    check("single_level1", level, 1);
    check("single_idle", busy, 0);
    tick();
    check("single_mul_rst", mul_rst, 1);
    check("single_start_lo", start, 0);
    check("single_data_a", data_a, 8'h03);
    check("single_data_b", data_b, 8'h05);
    check("single_level0", level, 0);
    tick();
    check("single_mul_rst_lo", mul_rst, 0);
    check("single_start", start, 1);
    tick();
    check("single_start_done", start, 0);
    check("single_wait_busy", busy, 1);
    tick();
    tick();
    mac_done = 1'b1;
    mac_sum  = 8'h0F;
    tick();
    mac_done = 1'b0;
    mac_sum  = 8'hFF;
    check("single_res_valid", res_valid, 1);
    check("single_res_data", res_data, 8'h0F);
    check("single_res_err", res_err, 0);

    // backpressure in EMIT
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_res_valid", res_valid, 1);
      check("bp_res_data", res_data, 8'h0F);
      check("bp_no_start", start, 0);
      check("bp_data_a", data_a, 8'h03);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_res_valid_clr", res_valid, 0);
    check("bp_idle", busy, 0);

    // stray done in IDLE (empty) and LOAD
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    check("stray_idle_res_valid", res_valid, 0);
    check("stray_idle_busy", busy, 0);
    push_word(16'h1122);
    mac_done = 1'b1;
    tick();
    check("stray_load_mul_rst", mul_rst, 1);
    check("stray_load_res_valid", res_valid, 0);
    tick();
    mac_done = 1'b0;
    check("stray_start", start, 1);
    check("stray_start_res_valid", res_valid, 0);
    tick();
    check("stray_wait_res_valid", res_valid, 0);
    check("stray_wait_busy", busy, 1);
    finish_op("stray_op", 8'h33);

    // full FIFO with result held off
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
    end
    check("full_level", level, DEPTH);
    check("full_in_ready", in_ready, 0);
    tick();
    tick();
    in_valid = 1'b0;
    check("full_level_hold", level, DEPTH);
    check("full_busy", busy, 1);
    for (int k = 0; k < DEPTH + 1; k++) begin
      w = words[k];
      if (k > 0) begin
        check("drain_idle", busy, 0);
        tick();
        check("drain_mul_rst", mul_rst, 1);
        check("drain_level", level, DEPTH - k);
        tick();
        check("drain_start", start, 1);
        tick();
      end
      check("drain_data_a", data_a, w[15:8]);
      check("drain_data_b", data_b, w[7:0]);
      s = w[15:8] ^ w[7:0];
      finish_op("drain", s);
    end
    check("drain_level_empty", level, 0);
    check("drain_in_ready", in_ready, 1);
    check("drain_final_idle", busy, 0);

    // reset mid-WAIT with two words queued
    in_valid = 1'b1;
    in_data  = 16'hA1A2; tick();
    in_data  = 16'hB1B2; tick();
    in_data  = 16'hC1C2; tick();
    in_valid = 1'b0;
    tick();
    check("rst_pre_level", level, 2);
    check("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("rst_post_busy", busy, 0);
    check("rst_post_level", level, 0);
    check("rst_post_mul_rst", mul_rst, 0);
    check("rst_post_res_valid", res_valid, 0);

    // watchdog
    mac_sum = 8'h5A;
    push_word(16'hABCD);
    tick();
    tick();
    tick();
    check("wd_in_wait", busy, 1);
`ifdef MAC_FEEDER_TIMEOUT_EN
    for (int i = 1; i < TIMEOUT; i++) tick();
    check("wd_before_expiry", res_valid, 0);
    tick();
    check("wd_expiry_valid", res_valid, 1);
    check("wd_expiry_err", res_err, 1);
    check("wd_expiry_data", res_data, 8'h5A);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("wd_expiry_clr", res_valid, 0);
    push_word(16'h0102);
    tick();
    tick();
    tick();
    for (int i = 1; i < TIMEOUT; i++) tick();
    mac_done = 1'b1;
    mac_sum  = 8'h6B;
    tick();
    mac_done = 1'b0;
    check("wd_tie_valid", res_valid, 1);
    check("wd_tie_err", res_err, 0);
    check("wd_tie_data", res_data, 8'h6B);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`else
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (res_valid) hi++;
    end
    check("wd_off_no_result", hi, 0);
    check("wd_off_still_busy", busy, 1);
    finish_op("wd_off_op", 8'h77);
`endif
    check("end_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
